edge2en_multi: RTL and testbench

Multi-channel, parametrised successor to the single-channel edge-to-enable converter. Each channel synchronises an asynchronous level input, debounces it with a runtime-programmable glitch filter, and emits a one-cycle enable on rising, falling or both edges as selected per channel. Per-channel sticky pending flags with a software clear and a combined interrupt output let a register block or interrupt controller consume events without polling the pulses. Sits between external pins or foreign-clock-domain levels and local control logic.

---
 rtl/edge2en_pkg.sv | 18 +
 rtl/edge2en_chan.sv | 85 ++++++++
 rtl/edge2en_multi.sv | 44 ++++
 tb/tb_edge2en_multi.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/edge2en_pkg.sv
// Shared types and constants for the multi-channel edge-to-enable converter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package edge2en_pkg;

  // Per-channel edge selection; bit 0 enables rising, bit 1 enables falling.
  typedef enum logic [1:0] {
    EDGE_NONE = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_e;

  localparam int MODE_W        = 2;
  localparam int MODE_RISE_BIT = 0;
  localparam int MODE_FALL_BIT = 1;

endpackage

// File: rtl/edge2en_chan.sv
// One channel: synchronise, debounce, emit a one-cycle edge enable, hold a sticky pending flag.
// Latency: SYNC_STG + deb_len + 1 edges from first sampling edge to out/en; pend one edge after en.
// Backpressure: none; en is fire-and-forget, pend holds until cleared by clr.
module edge2en_chan
  import edge2en_pkg::*;
#(
  parameter int SYNC_STG = 2,
  parameter int DEB_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in,
  input  logic [1:0]       mode,
  input  logic [DEB_W-1:0] deb_len,
  input  logic             clr,
  output logic             out,
  output logic             en,
  output logic             pend
);

  logic             s;
  logic [DEB_W-1:0] cnt;
  logic             accept;
  logic             permitted;
  edge_mode_e       emode;

  generate
    if (SYNC_STG == 0) begin : g_nosync
      assign s = in;
    end else begin : g_sync
      logic [SYNC_STG-1:0] sync;
      // Shift the raw level through the synchroniser chain.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          sync <= '0;
        end else begin
          sync[0] <= in;
          for (int i = 1; i < SYNC_STG; i++) begin
            sync[i] <= sync[i-1];
          end
        end
      end
      assign s = sync[SYNC_STG-1];
    end
  endgenerate

  assign emode = edge_mode_e'(mode);

  // Decide whether the sampled level is accepted this edge and whether its direction is reported.
  always_comb begin
    accept    = 1'b0;
    permitted = 1'b0;
    if ((s != out) && (cnt >= deb_len)) begin
      accept = 1'b1;
    end
    case (emode)
      EDGE_RISE: permitted = s;
      EDGE_FALL: permitted = ~s;
      EDGE_BOTH: permitted = 1'b1;
      default:   permitted = 1'b0;
    endcase
  end

  // Debounce counter, filtered level, edge enable and sticky pending (set beats clear).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt  <= '0;
      out  <= 1'b0;
      en   <= 1'b0;
      pend <= 1'b0;
    end else begin
      if (s == out) begin
        cnt <= '0;
      end else if (accept) begin
        out <= s;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      en   <= accept & permitted;
      pend <= en | (pend & ~clr);
    end
  end

endmodule

// File: rtl/edge2en_multi.sv
// CH independent edge-to-enable channels with a combined pending interrupt.
// Latency: per channel SYNC_STG + deb_len + 1 edges to out/en; irq follows pend combinationally.
// Backpressure: none; events are latched in pend until software clears them.
module edge2en_multi
  import edge2en_pkg::*;
#(
  parameter int CH       = 4,
  parameter int SYNC_STG = 2,
  parameter int DEB_W    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [CH-1:0]      in,
  input  logic [2*CH-1:0]    mode,
  input  logic [DEB_W-1:0]   deb_len,
  input  logic [CH-1:0]      clr,
  output logic [CH-1:0]      out,
  output logic [CH-1:0]      en,
  output logic [CH-1:0]      pend,
  output logic               irq
);

  generate
    for (genvar i = 0; i < CH; i++) begin : g_ch
      edge2en_chan #(
        .SYNC_STG (SYNC_STG),
        .DEB_W    (DEB_W)
      ) u_chan (
        .clk     (clk),
        .rst_n   (rst_n),
        .in      (in[i]),
        .mode    (mode[MODE_W*i +: MODE_W]),
        .deb_len (deb_len),
        .clr     (clr[i]),
        .out     (out[i]),
        .en      (en[i]),
        .pend    (pend[i])
      );
    end
  endgenerate

  assign irq = |pend;

endmodule

// File: tb/tb_edge2en_multi.sv
// Randomised and directed bench for edge2en_multi against a timestamp-based reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_edge2en_multi;
  import edge2en_pkg::*;

  localparam int CH       = 4;
  localparam int SYNC_STG = 2;
  localparam int DEB_W    = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [CH-1:0]     in;
  logic [2*CH-1:0]   mode;
  logic [DEB_W-1:0]  deb_len;
  logic [CH-1:0]     clr;
  logic [CH-1:0]     out;
  logic [CH-1:0]     en;
  logic [CH-1:0]     pend;
  logic              irq;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: pipeline of sampled levels and, per channel, the edge index
  // at which the current disagreement with the accepted level began.
  logic [CH-1:0] m_sync [SYNC_STG];
  logic [CH-1:0] m_out, m_en, m_pend;
  bit            m_mis [CH];
  int            m_since [CH];
  int            cyc = 0;

  edge2en_multi #(.CH(CH), .SYNC_STG(SYNC_STG), .DEB_W(DEB_W)) dut (
    .clk(clk), .rst_n(rst_n), .in(in), .mode(mode), .deb_len(deb_len),
    .clr(clr), .out(out), .en(en), .pend(pend), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    logic [CH-1:0] s, nen, npend;
    bit acc;
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STG; k++) m_sync[k] = '0;
      m_out = '0; m_en = '0; m_pend = '0;
      for (int c = 0; c < CH; c++) m_mis[c] = 0;
    end else begin
      s     = m_sync[SYNC_STG-1];
      npend = m_en | (m_pend & ~clr);
      nen   = '0;
      for (int c = 0; c < CH; c++) begin
        acc = 0;
        if (s[c] != m_out[c]) begin
          if (!m_mis[c]) begin
            m_mis[c]   = 1;
            m_since[c] = cyc;
          end
          if (cyc - m_since[c] >= int'(deb_len)) acc = 1;
        end else begin
          m_mis[c] = 0;
        end
        if (acc) begin
          nen[c]   = s[c] ? mode[2*c+MODE_RISE_BIT] : mode[2*c+MODE_FALL_BIT];
          m_out[c] = s[c];
          m_mis[c] = 0;
        end
      end
      m_en   = nen;
      m_pend = npend;
      for (int k = SYNC_STG-1; k > 0; k--) m_sync[k] = m_sync[k-1];
      m_sync[0] = in;
    end
    cyc++;
  endtask

  // One clock: update model, let the edge happen, compare all outputs just after it.
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("out",  32'(out),  32'(m_out));
    chk("en",   32'(en),   32'(m_en));
    chk("pend", 32'(pend), 32'(m_pend));
    chk("irq",  32'(irq),  32'(|m_pend));
  endtask

  task automatic run_mode(input logic [1:0] m, input int exp_en, input logic exp_pend);
    int cnt_en = 0;
    mode[5:4] = m;
    clr = '1; step(); clr = '0;
    in[2] = 1'b1;
    repeat (10) begin step(); if (en[2]) cnt_en++; end
    in[2] = 1'b0;
    repeat (10) begin step(); if (en[2]) cnt_en++; end
    chk("mode_en_count", cnt_en, exp_en);
    chk("mode_pend", 32'(pend[2]), 32'(exp_pend));
  endtask

  initial begin
    int n;
    bit seen;

    rst_n = 1'b0; in = '0; mode = '1; deb_len = '0; clr = '0;
    repeat (3) step();
    chk("rst_out", 32'(out), 0);
    chk("rst_en", 32'(en), 0);
    chk("rst_pend", 32'(pend), 0);
    chk("rst_irq", 32'(irq), 0);
    rst_n = 1'b1;
    repeat (3) step();

    // Latency with deb_len=0: SYNC_STG+1 edges.
    in[0] = 1'b1; n = 0; seen = 0;
    for (int k = 0; k < 30 && !seen; k++) begin step(); n++; if (en[0]) seen = 1; end
    chk("lat_deb0", n, 3);
    step();
    chk("pend_after_en", 32'(pend[0]), 1);
    chk("irq_after_en", 32'(irq), 1);

    // Debounce: 3-cycle glitch rejected, 4-cycle pulse accepted after SYNC_STG+4 edges.
    deb_len = 4'd3; seen = 0;
    in[1] = 1'b1; repeat (3) step(); in[1] = 1'b0;
    repeat (12) begin step(); if (en[1] || out[1]) seen = 1; end
    chk("glitch_rejected", 32'(seen), 0);
    in[1] = 1'b1; n = 0; seen = 0;
    for (int k = 0; k < 30 && !seen; k++) begin
      step(); n++;
      if (n == 4) in[1] = 1'b0;
      if (en[1]) seen = 1;
    end
    chk("lat_deb3", n, 6);
    repeat (10) step();

    // Edge mode filtering on channel 2.
    deb_len = 4'd2;
    run_mode(2'b01, 1, 1'b1);
    run_mode(2'b10, 1, 1'b1);
    run_mode(2'b00, 0, 1'b0);
    mode[5:4] = 2'b11;

    // Clear arriving on the edge that registers en: set wins, then clear takes effect.
    deb_len = 4'd0;
    clr = '1; step(); clr = '0;
    in[3] = 1'b1; seen = 0;
    for (int k = 0; k < 30 && !seen; k++) begin step(); if (en[3]) seen = 1; end
    chk("race_en_seen", 32'(seen), 1);
    clr[3] = 1'b1; step();
    chk("race_pend_held", 32'(pend[3]), 1);
    step(); clr[3] = 1'b0;
    chk("race_pend_cleared", 32'(pend[3]), 0);
    chk("race_irq_cleared", 32'(irq), 0);

    // Threshold lowered mid-count: 7 -> 1 with count at 4 accepts on the next edge.
    deb_len = 4'd7; in[1] = 1'b1;
    repeat (6) step();
    deb_len = 4'd1; step();
    chk("thr_en", 32'(en[1]), 1);
    chk("thr_out", 32'(out[1]), 1);

    // Reset during a partial count, input held high through release.
    deb_len = 4'd7; in[0] = 1'b0;
    repeat (5) step();
    rst_n = 1'b0; in = 4'b0001; step();
    chk("midrst_out", 32'(out), 0);
    chk("midrst_pend", 32'(pend), 0);
    chk("midrst_irq", 32'(irq), 0);
    rst_n = 1'b1; n = 0; seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin step(); n++; if (en[0]) seen = 1; end
    chk("lat_after_reset", n, 10);
    n = 0;
    repeat (20) begin step(); if (en[0]) n++; end
    chk("single_rise_after_reset", n, 0);

    // Random traffic.
    for (int t = 0; t < 3000; t++) begin
      for (int c = 0; c < CH; c++) if ($urandom_range(7) == 0) in[c] = ~in[c];
      clr = '0;
      for (int c = 0; c < CH; c++) if ($urandom_range(15) == 0) clr[c] = 1'b1;
      if ($urandom_range(99) == 0) mode = 8'($urandom);
      if ($urandom_range(149) == 0) deb_len = 4'($urandom_range(15));
      rst_n = ($urandom_range(599) != 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
